// File: rtl/pcs_tx_functions.sv
// 1000BASE-X PCS transmit helper functions: sticky XMITCHANGE detector
// (registered) and VOID /V/ substitution (combinational).
module pcs_tx_functions #(
  parameter int unsigned            XMIT_W = 3,
  parameter int unsigned            OS_W   = 9,
  parameter logic [OS_W-1:0]        OS_V   = 9'd64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XMIT_W-1:0] xmit,
  input  logic              xmit_change_clr,
  output logic              xmit_change_out,
  input  logic [OS_W-1:0]   x_in,
  input  logic              TX_EN,
  input  logic              TX_ER,
  input  logic [7:0]        TXD,
  output logic [OS_W-1:0]   void_return
);

  localparam logic [7:0] CARRIER_EXT = 8'h0F;

  logic [XMIT_W-1:0] xmit_prev;
  logic              primed;
  logic              xmit_diff;

  assign xmit_diff = (xmit != xmit_prev);

  // The first edge after reset only captures a baseline; a change against
  // the reset value of xmit_prev would be spurious.
  always_ff @(posedge clk) begin
    if (reset) begin
      xmit_prev       <= '0;
      primed          <= 1'b0;
      xmit_change_out <= 1'b0;
    end else begin
      xmit_prev <= xmit;
      if (!primed) begin
        primed <= 1'b1;
      end else if (xmit_diff) begin
        xmit_change_out <= 1'b1;
      end else if (xmit_change_clr) begin
        xmit_change_out <= 1'b0;
      end
    end
  end

  // Error outside a frame (carrier extend excluded) or inside a frame forces /V/.
  always_comb begin
    void_return = x_in;
    if (!TX_EN && TX_ER && (TXD != CARRIER_EXT))
      void_return = OS_V;
    else if (TX_EN && TX_ER)
      void_return = OS_V;
  end

endmodule

// File: tb/tb_pcs_tx_functions.sv
// Scoreboard bench for pcs_tx_functions: stimulus pushes expected results,
// a monitor pops and compares one cycle-sample per rising edge.
module tb_pcs_tx_functions;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] xmit;
  logic       xmit_change_clr;
  logic       xmit_change_out;
  logic [8:0] x_in;
  logic       TX_EN, TX_ER;
  logic [7:0] TXD;
  logic [8:0] void_return;

  always #5 clk = ~clk;

  pcs_tx_functions dut (
    .clk(clk), .reset(reset), .xmit(xmit), .xmit_change_clr(xmit_change_clr),
    .xmit_change_out(xmit_change_out), .x_in(x_in), .TX_EN(TX_EN),
    .TX_ER(TX_ER), .TXD(TXD), .void_return(void_return)
  );

  typedef struct {
    logic       flag;
    logic [8:0] vret;
    string      tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state: edge indices of the last reported change and the
  // last effective clear; a change is pending when the former is newer.
  int         edge_no;
  int         last_change;
  int         last_clear;
  bit         have_base;
  logic [2:0] base;

  function automatic logic [8:0] void_model(logic [8:0] x, logic en, logic er, logic [7:0] d);
    if (er && (en || d != 8'h0F)) return 9'd64;
    return x;
  endfunction

  task automatic step(input logic rst, input logic [2:0] xm, input logic clr,
                      input logic [8:0] xi, input logic en, input logic er,
                      input logic [7:0] d, input string tag);
    exp_t e;
    @(negedge clk);
    reset = rst; xmit = xm; xmit_change_clr = clr;
    x_in = xi; TX_EN = en; TX_ER = er; TXD = d;
    @(posedge clk);
    edge_no++;
    if (rst) begin
      have_base = 0; last_change = 0; last_clear = edge_no;
    end else if (!have_base) begin
      have_base = 1; base = xm;
    end else begin
      if (xm != base) last_change = edge_no;
      else if (clr) last_clear = edge_no;
      base = xm;
    end
    e.flag = (last_change > last_clear);
    e.vret = void_model(xi, en, er, d);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic xstep(input logic rst, input logic [2:0] xm, input logic clr, input string tag);
    step(rst, xm, clr, 9'd7, 1'b0, 1'b0, 8'hAA, tag);
  endtask

  // Monitor: sample #1 after each rising edge and compare with the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (xmit_change_out !== e.flag) begin
          n_fail++;
          $display("FAIL %s xmit_change_out: got %b want %b", e.tag, xmit_change_out, e.flag);
        end
        n_tests++;
        if (void_return !== e.vret) begin
          n_fail++;
          $display("FAIL %s return: got %0d want %0d", e.tag, void_return, e.vret);
        end
      end
    end
  end

  initial begin
    edge_no = 0; last_change = 0; last_clear = 0; have_base = 0; base = '0;
    reset = 1; xmit = 3'b001; xmit_change_clr = 0;
    x_in = 9'd7; TX_EN = 0; TX_ER = 0; TXD = 8'hAA;

    // XMITCHANGE directed sequence
    xstep(1, 3'b001, 0, "reset");
    for (int i = 0; i < 5; i++) xstep(0, 3'b001, 0, "prime_hold");
    xstep(0, 3'b010, 0, "change_set");
    for (int i = 0; i < 5; i++) xstep(0, 3'b010, 0, "sticky");
    xstep(0, 3'b001, 0, "second_change");
    xstep(0, 3'b001, 1, "clear");
    xstep(0, 3'b001, 0, "after_clear");
    xstep(0, 3'b100, 0, "set_again");
    xstep(0, 3'b010, 1, "set_beats_clear");
    xstep(0, 3'b010, 0, "still_set");
    xstep(1, 3'b010, 0, "mid_reset");
    xstep(0, 3'b110, 0, "new_baseline");
    xstep(0, 3'b110, 0, "baseline_hold");
    xstep(0, 3'b111, 0, "one_cycle_glitch");
    xstep(0, 3'b110, 1, "glitch_back_clr");
    xstep(0, 3'b110, 1, "glitch_clr");

    // VOID directed cases
    step(0, 3'b110, 0, 9'd7, 0, 1, 8'h00, "void_false_carrier");
    step(0, 3'b110, 0, 9'd7, 0, 1, 8'h0F, "void_carrier_ext");
    step(0, 3'b110, 0, 9'd7, 1, 1, 8'h0F, "void_in_frame_0F");
    step(0, 3'b110, 0, 9'd7, 1, 1, 8'h5C, "void_in_frame");
    step(0, 3'b110, 0, 9'd7, 1, 0, 8'h5C, "void_data");
    step(0, 3'b110, 0, 9'd7, 0, 0, 8'hAA, "void_idle");
    for (int i = 0; i < 512; i++)
      step(0, 3'b110, 0, 9'(i), 0, 0, 8'hAA, "void_sweep");

    // Randomized mix of both functions
    for (int i = 0; i < 2000; i++) begin
      logic [2:0] xm;
      xm = ($urandom_range(0, 3) == 0) ? 3'($urandom) : xmit;
      step(($urandom_range(0, 49) == 0), xm, ($urandom_range(0, 3) == 0),
           9'($urandom), 1'($urandom), 1'($urandom),
           ($urandom_range(0, 3) == 0) ? 8'h0F : 8'($urandom), "random");
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pcs_tx_functions.md
# pcs_tx_functions

Helper-function block for the 1000BASE-X PCS transmit ordered-set state machine. It provides two services. XMITCHANGE is a registered, sticky detector that flags any change of the `xmit` variable. VOID is a combinational substitution that replaces a candidate ordered-set code with /V/ (error propagation) when the GMII transmit controls demand it. It sits between the GMII transmit inputs and the PCS transmit ordered-set FSM, which consumes both results.

## Interface
Parameters:
- `XMIT_W`, default 3: width of the `xmit` variable.
- `OS_W`, default 9: width of an ordered-set code.
- `OS_V`, default 9'd64: ordered-set code for /V/.

Ports:
- `clk`, input, 1: GTX_CLK transmit clock. Single clock domain; all state updates on the rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `xmit`, input, XMIT_W: current xmit value, e.g. 3'b001 / 3'b010.
- `xmit_change_clr`, input, 1: clears the sticky change flag. Pulsed by the TX FSM when it consumes the change.
- `xmit_change_out`, output, 1: registered XMITCHANGE result (TRUE = change pending).
- `x_in`, input, OS_W: candidate ordered-set code (the VOID argument).
- `TX_EN`, input, 1: GMII transmit enable.
- `TX_ER`, input, 1: GMII transmit coding error.
- `TXD`, input, 8: GMII transmit data.
- `return`, output, OS_W: VOID result; purely combinational.

## Operation
XMITCHANGE:
- Internal registers:
  - `xmit_prev` (XMIT_W bits)
  - `primed` (1 bit)
  - `xmit_change_out` (1 bit)
- Reset: `xmit_prev`=0, `primed`=0, `xmit_change_out`=0.
- First edge after reset (`primed`=0):
  - `xmit_prev` <= `xmit`.
  - `primed` <= 1.
  - No change is reported.
- Later edges:
  - `xmit_prev` <= `xmit` on every edge.
  - If `xmit` != `xmit_prev` (any bit differs), `xmit_change_out` <= 1.
  - Else if `xmit_change_clr`=1, `xmit_change_out` <= 0.
  - Otherwise the flag holds.
- Set has priority over clear when a change and `xmit_change_clr` occur on the same edge.
- The flag is sticky. Multiple changes before a clear still produce a single 1.

VOID (combinational, evaluated in this priority order):
1. `TX_EN`=0, `TX_ER`=1 and `TXD` != 8'h0F: `return` = OS_V. This is a false carrier / error outside a frame. The carrier-extend pattern 8'h0F is excluded.
2. `TX_EN`=1 and `TX_ER`=1: `return` = OS_V. This is an error inside a frame; `TXD` is ignored.
3. Otherwise: `return` = `x_in`, unchanged, for all OS_W bits.

General rules:
- VOID has no state and is unaffected by `clk` and `reset`.
- No X-propagation masking. Inputs are assumed driven.

## Timing
- `xmit_change_out` latency:
  - `xmit` changes before edge N; the flag is high after edge N (1 cycle).
  - It stays high until the first edge where `xmit_change_clr`=1 and no new change is detected.
- A change lasting one cycle is caught, provided it is stable across one rising edge.
- Reset asserted mid-operation: on the next edge the flag drops to 0 and `primed` clears. The `xmit` value present after reset releases becomes the new baseline and is not reported.
- `return` settles within the same cycle as any input change (zero cycle latency). The registering point is owned by the consumer.

## Test plan
- Reset, then `xmit`=3'b001 for 5 cycles -> `xmit_change_out`=0 throughout, including the priming cycle.
- `xmit` 3'b001→3'b010 with `xmit_change_clr`=0 -> `xmit_change_out`=1 after the next edge. It stays 1 for 5+ cycles; a later 3'b010→3'b001 keeps it at 1.
- `xmit_change_out`=1, pulse `xmit_change_clr` for 1 cycle with stable `xmit` -> flag 0 after that edge. Repeat with a simultaneous `xmit` change -> flag stays 1. Assert `reset` mid-sequence -> flag 0 on the next edge.
- `x_in`=7, `TX_EN`=0, `TX_ER`=1, `TXD`=8'h00 -> `return`=64. Same inputs with `TXD`=8'h0F -> `return`=7.
- `x_in`=7, `TX_EN`=1, `TX_ER`=1, any `TXD` -> `return`=64. `TX_EN`=1, `TX_ER`=0 -> `return`=7.
- `x_in`=7, `TX_EN`=0, `TX_ER`=0, `TXD`=8'hAA -> `return`=7. Sweep `x_in` 0..511 in this mode -> `return`=`x_in` exactly.
